// File: rtl/soml_decoder.sv
// soml_decoder: 4x4 MIMO spatial-modulation SOML detector, 2 slots/frame.
// Loads H and Y, scans one transmit antenna per cycle, slices 16-QAM.
module soml_decoder #(
  parameter int Q = 22,
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                H_in_valid,
  input  logic signed [N-1:0] H_in_r,
  input  logic signed [N-1:0] H_in_i,
  input  logic                Y_in_valid,
  input  logic signed [N-1:0] Y_in_r,
  input  logic signed [N-1:0] Y_in_i,
  output logic                output_valid,
  output logic signed [N-1:0] s_I_1,
  output logic signed [N-1:0] s_Q_1,
  output logic signed [N-1:0] s_I_2,
  output logic signed [N-1:0] s_Q_2,
  output logic [4:0]          Smin_index,
  output logic [11:0]         signal_out_12bit
);

  localparam int AW = N + 4;
  localparam int PW = 2 * AW;

  typedef logic signed [AW-1:0] acc_t;
  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;

  localparam acc_t A1    = acc_t'(1326356);
  localparam acc_t A3    = acc_t'(3979068);
  localparam acc_t TWO_A = acc_t'(2652712);

  function automatic acc_t ext(input logic signed [N-1:0] x);
    return {{(AW-N){x[N-1]}}, x};
  endfunction

  function automatic acc_t qmul(input acc_t a, input acc_t b);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return acc_t'(p >>> Q);
  endfunction

  // Gray code of the nearest level; t is never negative (g >= 0)
  function automatic logic [1:0] slice(input acc_t x, input acc_t t);
    if (x >= t)
      return 2'b10;
    else if (!x[AW-1])
      return 2'b11;
    else if (x >= -t)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic acc_t level(input logic [1:0] c);
    acc_t v;
    unique case (c)
      2'b00:   v = -A3;
      2'b01:   v = -A1;
      2'b11:   v = A1;
      default: v = A3;
    endcase
    return v;
  endfunction

  state_t state, state_nx;

  logic [4:0] h_cnt, h_cnt_nx;
  logic [3:0] y_cnt, y_cnt_nx;
  logic [2:0] ev_cnt;
  logic [1:0] ev_a;
  logic       h_fire, y_fire, load_done;
  logic       ev_en, enc_en;

  logic signed [N-1:0] h_r [16];
  logic signed [N-1:0] h_i [16];
  logic signed [N-1:0] y_r [8];
  logic signed [N-1:0] y_i [8];

  acc_t       re [2];
  acc_t       im [2];
  acc_t       g  [2];
  acc_t       m  [2];
  logic [1:0] ci [2];
  logic [1:0] cq [2];

  acc_t       best_m  [2];
  logic [1:0] best_a  [2];
  logic [1:0] best_ci [2];
  logic [1:0] best_cq [2];

  assign h_fire = (state == LOAD) && !start && H_in_valid && !h_cnt[4];
  assign y_fire = (state == LOAD) && !start && Y_in_valid && !y_cnt[3];
  assign h_cnt_nx = h_cnt + 5'(h_fire);
  assign y_cnt_nx = y_cnt + 4'(y_fire);
  assign load_done = h_cnt_nx[4] && y_cnt_nx[3];
  assign ev_a = ev_cnt[1:0];
  assign ev_en = (state == EVAL) && !ev_cnt[2] && !start;
  assign enc_en = (state == EVAL) && (ev_cnt == 3'd4) && !start;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next state: start always reopens a frame
  always_comb begin
    state_nx = state;
    if (start)
      state_nx = LOAD;
    else begin
      case (state)
        LOAD:    if (load_done) state_nx = EVAL;
        EVAL:    if (ev_cnt == 3'd4) state_nx = DONE;
        default: state_nx = state;
      endcase
    end
  end

  // Beat and antenna-scan counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt  <= '0;
      y_cnt  <= '0;
      ev_cnt <= '0;
    end else begin
      h_cnt  <= start ? '0 : h_cnt_nx;
      y_cnt  <= start ? '0 : y_cnt_nx;
      if ((state == EVAL) && !start)
        ev_cnt <= ev_cnt + 3'd1;
      else
        ev_cnt <= '0;
    end
  end

  // Sample storage; contents are don't-care until counted in
  always_ff @(posedge clk) begin
    if (h_fire) begin
      h_r[h_cnt[3:0]] <= H_in_r;
      h_i[h_cnt[3:0]] <= H_in_i;
    end
    if (y_fire) begin
      y_r[y_cnt[2:0]] <= Y_in_r;
      y_i[y_cnt[2:0]] <= Y_in_i;
    end
  end

  // Matched filter, gain, slicer and metric for both slots
  always_comb begin
    for (int t = 0; t < 2; t++) begin
      acc_t tq, si, sq, pw;
      re[t] = '0;
      im[t] = '0;
      g[t]  = '0;
      for (int r = 0; r < 4; r++) begin
        acc_t hr, hi, yr, yi;
        hr = ext(h_r[{r[1:0], ev_a}]);
        hi = ext(h_i[{r[1:0], ev_a}]);
        yr = ext(y_r[{t[0], r[1:0]}]);
        yi = ext(y_i[{t[0], r[1:0]}]);
        re[t] = re[t] + qmul(hr, yr) + qmul(hi, yi);
        im[t] = im[t] + qmul(hr, yi) - qmul(hi, yr);
        g[t]  = g[t] + qmul(hr, hr) + qmul(hi, hi);
      end
      tq = qmul(TWO_A, g[t]);
      ci[t] = slice(re[t], tq);
      cq[t] = slice(im[t], tq);
      si = level(ci[t]);
      sq = level(cq[t]);
      pw = qmul(si, si) + qmul(sq, sq);
      m[t] = qmul(g[t], pw)
           - ((qmul(si, re[t]) + qmul(sq, im[t])) <<< 1);
    end
  end

  // Running minimum; strict compare keeps the lower antenna on ties
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < 2; t++) begin
        best_m[t]  <= '0;
        best_a[t]  <= '0;
        best_ci[t] <= '0;
        best_cq[t] <= '0;
      end
    end else if (ev_en) begin
      for (int t = 0; t < 2; t++) begin
        if ((ev_cnt == 3'd0) || (m[t] < best_m[t])) begin
          best_m[t]  <= m[t];
          best_a[t]  <= ev_a;
          best_ci[t] <= ci[t];
          best_cq[t] <= cq[t];
        end
      end
    end
  end

  // Result registers, held until the next start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || start) begin
      output_valid     <= 1'b0;
      s_I_1            <= '0;
      s_Q_1            <= '0;
      s_I_2            <= '0;
      s_Q_2            <= '0;
      Smin_index       <= '0;
      signal_out_12bit <= '0;
    end else if (enc_en) begin
      output_valid     <= 1'b1;
      s_I_1            <= N'(level(best_ci[0]));
      s_Q_1            <= N'(level(best_cq[0]));
      s_I_2            <= N'(level(best_ci[1]));
      s_Q_2            <= N'(level(best_cq[1]));
      Smin_index       <= {1'b0, best_a[0], best_a[1]};
      signal_out_12bit <= {best_a[0], best_a[1],
                           best_ci[0], best_cq[0],
                           best_ci[1], best_cq[1]};
    end
  end

endmodule

// File: tb/tb_soml_decoder.sv
// tb_soml_decoder: directed + random frames for soml_decoder.
// Expected results queued at drive time, checked when output_valid rises.
module tb_soml_decoder;

  localparam int N = 32;
  localparam int Q = 22;
  localparam longint A = 1326356;
  localparam longint ONE = 4194304;

  typedef struct packed {
    logic [4:0]   idx;
    logic [N-1:0] si1;
    logic [N-1:0] sq1;
    logic [N-1:0] si2;
    logic [N-1:0] sq2;
    logic [11:0]  bits;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         H_in_valid = 1'b0;
  logic [N-1:0] H_in_r = '0;
  logic [N-1:0] H_in_i = '0;
  logic         Y_in_valid = 1'b0;
  logic [N-1:0] Y_in_r = '0;
  logic [N-1:0] Y_in_i = '0;
  logic         output_valid;
  logic [N-1:0] s_I_1, s_Q_1, s_I_2, s_Q_2;
  logic [4:0]   Smin_index;
  logic [11:0]  signal_out_12bit;

  soml_decoder #(.Q(Q), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .H_in_valid(H_in_valid), .H_in_r(H_in_r), .H_in_i(H_in_i),
    .Y_in_valid(Y_in_valid), .Y_in_r(Y_in_r), .Y_in_i(Y_in_i),
    .output_valid(output_valid),
    .s_I_1(s_I_1), .s_Q_1(s_Q_1), .s_I_2(s_I_2), .s_Q_2(s_Q_2),
    .Smin_index(Smin_index), .signal_out_12bit(signal_out_12bit)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     failures = 0;
  int     rises = 0;
  logic   prev_v = 1'b0;
  exp_t   sb[$];
  longint hr[16], hi[16], yr[8], yi[8];
  logic [11:0] tx_bits;

  always @(negedge clk) begin
    if (output_valid && !prev_v) rises++;
    prev_v = output_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint lvl(input int c);
    case (c)
      0: return -3 * A;
      1: return -A;
      3: return A;
      default: return 3 * A;
    endcase
  endfunction

  function automatic logic [1:0] gray(input longint s);
    if (s == 3 * A) return 2'b10;
    if (s == A) return 2'b11;
    if (s == -A) return 2'b01;
    return 2'b00;
  endfunction

  function automatic longint slc(input longint x, input longint t);
    if (x >= t) return 3 * A;
    if (x >= 0) return A;
    if (x >= -t) return -A;
    return -3 * A;
  endfunction

  function automatic exp_t model();
    exp_t   e;
    longint si[2], sq[2];
    int     ba[2];
    for (int t = 0; t < 2; t++) begin
      longint best = 0;
      for (int a = 0; a < 4; a++) begin
        longint re = 0, im = 0, g = 0, th, pi, pq, m;
        for (int r = 0; r < 4; r++) begin
          longint h_r = hr[r*4+a], h_i = hi[r*4+a];
          longint y_r = yr[t*4+r], y_i = yi[t*4+r];
          re += ((h_r * y_r) >>> Q) + ((h_i * y_i) >>> Q);
          im += ((h_r * y_i) >>> Q) - ((h_i * y_r) >>> Q);
          g  += ((h_r * h_r) >>> Q) + ((h_i * h_i) >>> Q);
        end
        th = (2 * A * g) >>> Q;
        pi = slc(re, th);
        pq = slc(im, th);
        m = ((g * (((pi * pi) >>> Q) + ((pq * pq) >>> Q))) >>> Q)
          - 2 * (((pi * re) >>> Q) + ((pq * im) >>> Q));
        if (a == 0 || m < best) begin
          best = m; ba[t] = a; si[t] = pi; sq[t] = pq;
        end
      end
    end
    e.idx  = {1'b0, 2'(ba[0]), 2'(ba[1])};
    e.si1  = N'(si[0]);
    e.sq1  = N'(sq[0]);
    e.si2  = N'(si[1]);
    e.sq2  = N'(sq[1]);
    e.bits = {2'(ba[0]), 2'(ba[1]), gray(si[0]), gray(sq[0]),
              gray(si[1]), gray(sq[1])};
    return e;
  endfunction

  task automatic set_identity();
    for (int k = 0; k < 16; k++) begin
      hr[k] = (k % 5 == 0) ? ONE : 0;
      hi[k] = 0;
    end
    for (int k = 0; k < 8; k++) begin
      yr[k] = 0;
      yi[k] = 0;
    end
  endtask

  task automatic set_single_path();
    set_identity();
    yr[2] = 3 * A;
    yi[2] = A;
    yr[5] = -A;
    yi[5] = -3 * A;
  endtask

  task automatic set_random();
    int a[2], c[4];
    for (int k = 0; k < 16; k++) begin
      hr[k] = longint'($urandom_range(0, 8388608)) - ONE;
      hi[k] = longint'($urandom_range(0, 8388608)) - ONE;
    end
    for (int t = 0; t < 2; t++) a[t] = int'($urandom_range(0, 3));
    for (int j = 0; j < 4; j++) c[j] = int'($urandom_range(0, 3));
    for (int t = 0; t < 2; t++) begin
      longint s_i = lvl(c[2*t]), s_q = lvl(c[2*t+1]);
      for (int r = 0; r < 4; r++) begin
        longint h_r = hr[r*4+a[t]], h_i = hi[r*4+a[t]];
        yr[t*4+r] = ((h_r * s_i) >>> Q) - ((h_i * s_q) >>> Q);
        yi[t*4+r] = ((h_r * s_q) >>> Q) + ((h_i * s_i) >>> Q);
      end
    end
    tx_bits = {2'(a[0]), 2'(a[1]), 2'(c[0]), 2'(c[1]),
               2'(c[2]), 2'(c[3])};
  endtask

  task automatic pulse_start(input bit junk);
    @(negedge clk);
    start = 1'b1;
    H_in_valid = junk;
    Y_in_valid = junk;
    H_in_r = 32'h7F00_1234;
    Y_in_r = 32'h7F00_5678;
    @(negedge clk);
    start = 1'b0;
    H_in_valid = 1'b0;
    Y_in_valid = 1'b0;
  endtask

  // mode 0: H and Y concurrent; mode 1: Y first plus 2 surplus beats,
  // then H with idle gaps
  task automatic send_frame(input int mode);
    if (mode == 0) begin
      for (int k = 0; k < 16; k++) begin
        H_in_valid = 1'b1;
        H_in_r = hr[k][N-1:0];
        H_in_i = hi[k][N-1:0];
        Y_in_valid = (k < 8);
        if (k < 8) begin
          Y_in_r = yr[k][N-1:0];
          Y_in_i = yi[k][N-1:0];
        end
        @(negedge clk);
      end
    end else begin
      for (int k = 0; k < 10; k++) begin
        Y_in_valid = 1'b1;
        Y_in_r = (k < 8) ? yr[k][N-1:0] : 32'h5A5A_5A5A;
        Y_in_i = (k < 8) ? yi[k][N-1:0] : 32'hA5A5_A5A5;
        @(negedge clk);
      end
      Y_in_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (k % 4 == 3) begin
          H_in_valid = 1'b0;
          @(negedge clk);
        end
        H_in_valid = 1'b1;
        H_in_r = hr[k][N-1:0];
        H_in_i = hi[k][N-1:0];
        @(negedge clk);
      end
    end
    H_in_valid = 1'b0;
    Y_in_valid = 1'b0;
  endtask

  task automatic finish_frame(input bit chk_lat);
    int   cyc = 1;
    exp_t e;
    while (!output_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("output_valid", 64'(output_valid), 64'(1));
    if (chk_lat) chk("latency", 64'(cyc), 64'(6));
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      chk("Smin_index", 64'(Smin_index), 64'(e.idx));
      chk("s_I_1", 64'(s_I_1), 64'(e.si1));
      chk("s_Q_1", 64'(s_Q_1), 64'(e.sq1));
      chk("s_I_2", 64'(s_I_2), 64'(e.si2));
      chk("s_Q_2", 64'(s_Q_2), 64'(e.sq2));
      chk("signal_out_12bit", 64'(signal_out_12bit), 64'(e.bits));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {output_valid, Smin_index, signal_out_12bit, s_I_1},
        64'(0));
    chk(tag, {s_Q_1, s_I_2}, 64'(0));
    chk(tag, 64'(s_Q_2), 64'(0));
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst = 1'b1;

    // Zero frame: all metrics tie, antenna 0 and +A everywhere
    set_identity();
    e = '{idx: 5'd0, si1: N'(A), sq1: N'(A), si2: N'(A), sq2: N'(A),
          bits: 12'h0FF};
    sb.push_back(e);
    pulse_start(1'b0);
    send_frame(0);
    finish_frame(1'b1);
    repeat (3) @(negedge clk);
    chk("valid_holds", 64'(output_valid), 64'(1));
    start = 1'b1;
    chk("valid_before_start_edge", 64'(output_valid), 64'(1));
    @(negedge clk);
    start = 1'b0;
    chk("valid_drops_on_start", 64'(output_valid), 64'(0));

    // Single-path frame, Y first with surplus beats
    set_single_path();
    e = '{idx: 5'd9, si1: N'(3 * A), sq1: N'(A), si2: N'(-A),
          sq2: N'(-3 * A), bits: 12'h9B4};
    sb.push_back(e);
    send_frame(1);
    finish_frame(1'b0);

    // Restart after 7 H beats; junk beats in the start cycle
    pulse_start(1'b0);
    rises = 0;
    for (int k = 0; k < 7; k++) begin
      H_in_valid = 1'b1;
      H_in_r = 32'h0123_4567;
      H_in_i = 32'h0765_4321;
      @(negedge clk);
    end
    H_in_valid = 1'b0;
    sb.push_back(e);
    pulse_start(1'b1);
    send_frame(0);
    finish_frame(1'b1);
    repeat (4) @(negedge clk);
    chk("restart_single_valid", 64'(rises), 64'(1));

    // Reset while results are held
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset_in_done");
    rst = 1'b1;

    // Reset in the middle of EVAL
    set_random();
    pulse_start(1'b0);
    send_frame(0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset_mid_eval");
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("aborted_no_valid", 64'(output_valid), 64'(0));
    sb.push_back(model());
    pulse_start(1'b0);
    send_frame(0);
    finish_frame(1'b1);
    chk("post_reset_bits", 64'(signal_out_12bit), 64'(tx_bits));

    // Random noise-free regression
    for (int f = 0; f < 50; f++) begin
      set_random();
      sb.push_back(model());
      pulse_start(1'b0);
      send_frame(f % 2);
      finish_frame(f % 2 == 0);
      chk("tx_bits", 64'(signal_out_12bit), 64'(tx_bits));
    end

    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
